// File: rtl/sram_piso_pkg.sv
// Shared defaults and FSM state encoding for the SRAM-to-serial reader.
package sram_piso_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;
endpackage

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter with ready/valid output and last-bit flag.
module piso_shifter #(
    parameter int DATA_W    = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              is_last_word,
    input  logic              ready,
    output logic              ser_data,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              word_end
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_word;
    logic              hs;

    assign ser_valid = (bit_cnt != '0);
    assign hs        = ser_valid & ready;
    assign word_end  = hs & (bit_cnt == CNT_W'(1));
    assign ser_last  = last_word & (bit_cnt == CNT_W'(1));
    assign ser_data  = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];

    // The parent only asserts load when empty or on the final handshake, so load wins over shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            last_word <= 1'b0;
        end else if (load) begin
            shreg     <= load_data;
            bit_cnt   <= CNT_W'(DATA_W);
            last_word <= is_last_word;
        end else if (hs) begin
            shreg   <= MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/sram_piso_reader.sv
// Reads a window of SRAM words one at a time and streams each word out serially.
module sram_piso_reader
    import sram_piso_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              sram_ren,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_rvalid,
    output logic              ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last
);
    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_left;
    logic              outstanding;
    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic              hold_last;
    logic              word_end;
    logic              shift_load;
    logic              issue;
    logic              capture;

    assign shift_load = hold_full & (~ser_valid | word_end);
    assign issue      = (state == RUN) & (rd_left != '0) & ~outstanding & (~hold_full | shift_load);
    assign capture    = sram_rvalid & outstanding;
    assign sram_ren   = issue;
    assign sram_raddr = rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_addr     <= '0;
            rd_left     <= '0;
            outstanding <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            hold_last   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (issue) begin
                rd_addr     <= rd_addr + 1'b1;
                rd_left     <= rd_left - 1'b1;
                outstanding <= 1'b1;
            end
            // A return only arrives after issue has drained hold, so capture and shift_load never overlap.
            if (capture) begin
                outstanding <= 1'b0;
                hold        <= sram_rdata;
                hold_full   <= 1'b1;
                hold_last   <= (rd_left == '0);
            end else if (shift_load) begin
                hold_full <= 1'b0;
            end
            case (state)
                IDLE: if (start) begin
                    rd_addr <= start_addr;
                    rd_left <= num_words;
                    busy    <= 1'b1;
                    state   <= (num_words == '0) ? FIN : RUN;
                end
                RUN: if (rd_left == '0) state <= DRAIN;
                DRAIN: if (~hold_full & word_end & ser_last) state <= FIN;
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    piso_shifter #(
        .DATA_W   (DATA_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load        (shift_load),
        .load_data   (hold),
        .is_last_word(hold_last),
        .ready       (ser_ready),
        .ser_data    (ser_data),
        .ser_valid   (ser_valid),
        .ser_last    (ser_last),
        .word_end    (word_end)
    );
endmodule

// File: tb/tb_sram_piso_reader.sv
// Directed bench for sram_piso_reader with a variable-latency SRAM model and serial monitor.
module tb_sram_piso_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  start_addr = '0;
    logic [6:0]  num_words = '0;
    logic        busy, done, sram_ren, ser_data, ser_valid, ser_ready, ser_last;
    logic [5:0]  sram_raddr;
    logic [31:0] sram_rdata;
    logic        sram_rvalid;

    logic [31:0] mem [64];
    int          lat = 1;
    logic        spur = 1'b0;
    logic        model_valid = 1'b0;
    logic [31:0] model_rdata = '0;
    int          pend = 0;
    logic [5:0]  paddr = '0;
    int          overlap = 0;
    logic        toggle_mode = 1'b0, tog = 1'b0, ready_lvl = 1'b1;

    assign ser_ready   = toggle_mode ? tog : ready_lvl;
    assign sram_rvalid = model_valid | spur;
    assign sram_rdata  = spur ? 32'hDEADBEEF : model_rdata;

    always #5 clk = ~clk;

    sram_piso_reader dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_words(num_words),
        .busy(busy), .done(done), .sram_ren(sram_ren), .sram_raddr(sram_raddr),
        .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid), .ser_data(ser_data),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last)
    );

    // SRAM model: one returned word per read, `lat` cycles after ren.
    always @(posedge clk) begin
        tog         <= ~tog;
        model_valid <= 1'b0;
        if (sram_ren) begin
            if (pend != 0 || model_valid) overlap <= overlap + 1;
            paddr <= sram_raddr;
            if (lat <= 1) begin
                model_valid <= 1'b1;
                model_rdata <= mem[sram_raddr];
                pend        <= 0;
            end else begin
                pend <= lat - 1;
            end
        end else if (pend != 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                model_valid <= 1'b1;
                model_rdata <= mem[paddr];
            end
        end
    end

    int          cyc = 0, nbits = 0, ren_n = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
    int          last_cnt = 0, last_idx = -1, stall_err = 0, stall_n = 0;
    logic        bits_arr [1024];
    int          bit_cyc [1024];
    logic [5:0]  ren_addr [256];
    logic        prev_stall = 1'b0, prev_data = 1'b0, prev_last = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (start && !busy) acc_cyc <= cyc;
            if (sram_ren) begin
                ren_addr[ren_n] <= sram_raddr;
                ren_n <= ren_n + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (ser_valid && ser_ready) begin
                bits_arr[nbits] <= ser_data;
                bit_cyc[nbits]  <= cyc;
                nbits <= nbits + 1;
                if (ser_last) begin
                    last_cnt <= last_cnt + 1;
                    last_idx <= nbits;
                end
            end
            if (prev_stall && (!ser_valid || ser_data !== prev_data || ser_last !== prev_last))
                stall_err <= stall_err + 1;
            if (ser_valid && !ser_ready) stall_n <= stall_n + 1;
            prev_stall <= ser_valid && !ser_ready;
            prev_data  <= ser_data;
            prev_last  <= ser_last;
        end
    end

    int          checks = 0, errors = 0;
    logic [31:0] exp_w [8];
    logic [5:0]  exp_a [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] a, input logic [6:0] n);
        start_addr = a;
        num_words  = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, (done_cnt != d0), 1);
    endtask

    task automatic check_stream(input string tag, input int base, input int nw);
        int bad = 0;
        logic [31:0] wv;
        for (int w = 0; w < nw; w++) begin
            wv = exp_w[w];
            for (int k = 0; k < 32; k++)
                if (bits_arr[base + w * 32 + k] !== wv[31 - k]) bad++;
        end
        check({tag, "_bits"}, bad, 0);
    endtask

    task automatic check_ren(input string tag, input int base, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (ren_addr[base + i] !== exp_a[i]) bad++;
        check({tag, "_ren_n"}, ren_n - base, n);
        check({tag, "_raddr_seq"}, bad, 0);
    endtask

    initial begin
        int b, r, d, lc, sn, se, n;
        for (int i = 0; i < 64; i++) mem[i] = (32'(i) * 32'h01010101) ^ 32'h5A3C96E1;

        // Reset values
        tick();
        tick();
        check("reset_outputs", {busy, done, sram_ren, ser_valid, ser_last, ser_data, sram_raddr}, 0);
        rst = 1'b0;
        tick();

        // 1: two words, 1-cycle SRAM, ready held high
        mem[1] = 32'h00000001;
        mem[2] = 32'h00000002;
        exp_w[0] = 32'h00000001; exp_w[1] = 32'h00000002;
        exp_a[0] = 6'd1; exp_a[1] = 6'd2;
        b = nbits; r = ren_n; lc = last_cnt;
        do_start(6'd1, 7'd2);
        check("t1_first_ren", {busy, sram_ren, sram_raddr}, {1'b1, 1'b1, 6'd1});
        wait_done(300, "t1");
        check("t1_nbits", nbits - b, 64);
        check_stream("t1", b, 2);
        check_ren("t1", r, 2);
        check("t1_last_cnt", last_cnt - lc, 1);
        check("t1_last_idx", last_idx, b + 63);
        check("t1_first_bit_latency", bit_cyc[b] - acc_cyc, 4);
        check("t1_gapless", bit_cyc[b + 63] - bit_cyc[b], 63);
        check("t1_done_after_last", done_cyc - bit_cyc[b + 63], 2);
        check("t1_busy_low", busy, 0);
        tick();

        // 2: zero-length request
        r = ren_n;
        do_start(6'd9, 7'd0);
        check("t2_cycle1", {busy, done, sram_ren}, 3'b100);
        tick();
        check("t2_cycle2", {busy, done}, 2'b01);
        tick();
        check("t2_cycle3", {busy, done}, 2'b00);
        check("t2_no_ren", ren_n - r, 0);

        // 3: address wrap 62,63,0,1
        exp_w[0] = mem[62]; exp_w[1] = mem[63]; exp_w[2] = mem[0]; exp_w[3] = mem[1];
        exp_a[0] = 6'd62; exp_a[1] = 6'd63; exp_a[2] = 6'd0; exp_a[3] = 6'd1;
        b = nbits; r = ren_n;
        do_start(6'd62, 7'd4);
        wait_done(500, "t3");
        check("t3_nbits", nbits - b, 128);
        check_stream("t3", b, 4);
        check_ren("t3", r, 4);
        check("t3_last_idx", last_idx, b + 127);
        tick();

        // 4: ready toggling every cycle
        mem[7] = 32'hA5A5A5A5;
        exp_w[0] = 32'hA5A5A5A5;
        b = nbits; sn = stall_n; se = stall_err;
        toggle_mode = 1'b1;
        do_start(6'd7, 7'd1);
        wait_done(300, "t4");
        toggle_mode = 1'b0;
        check("t4_nbits", nbits - b, 32);
        check_stream("t4", b, 1);
        check("t4_stall_stable", stall_err - se, 0);
        check("t4_stalls_seen", (stall_n > sn), 1);
        tick();

        // 5: 3-cycle SRAM plus a spurious rvalid while idle
        lat = 3;
        b = nbits; r = ren_n;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t5_spurious_ignored", {busy, ser_valid, nbits - b}, 0);
        exp_w[0] = mem[10]; exp_w[1] = mem[11];
        exp_a[0] = 6'd10; exp_a[1] = 6'd11;
        do_start(6'd10, 7'd2);
        wait_done(600, "t5");
        check("t5_single_outstanding", overlap, 0);
        check("t5_nbits", nbits - b, 64);
        check_stream("t5", b, 2);
        check_ren("t5", r, 2);
        lat = 1;
        tick();
        tick();

        // 6: reset in the middle of word 0, then a fresh run
        d = done_cnt;
        b = nbits;
        n = 0;
        do_start(6'd0, 7'd2);
        while (nbits - b < 10 && n < 100) begin
            tick();
            n++;
        end
        check("t6_reached_bit10", (nbits - b >= 10), 1);
        rst = 1'b1;
        tick();
        check("t6_outputs_in_rst", {busy, done, sram_ren, ser_valid, ser_last, ser_data, sram_raddr}, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("t6_idle_after_rst", {busy, done, ser_valid}, 0);
        check("t6_no_done", done_cnt - d, 0);
        exp_w[0] = mem[5];
        b = nbits;
        do_start(6'd5, 7'd1);
        wait_done(300, "t6");
        check("t6_nbits", nbits - b, 32);
        check_stream("t6", b, 1);
        check("t6_single_done", done_cnt - d, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
